// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared FIFO data width and arbiter state encoding
package fifo_wr_arbiter_pkg;
    localparam int FIFO_DW = 8;
    typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// fifo_wr_arbiter_rr_pick: round-robin search for the first eligible requester after last_id
module fifo_wr_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_id,
    input  logic [N_REQ-1:0] excl,
    output logic             found,
    output logic [IW-1:0]    idx
);
    logic [N_REQ-1:0] rot;
    logic [IW:0]      start;
    int               off;
    int               pos;
    assign start = {1'b0, last_id} + 1'b1;
    assign rot   = N_REQ'({req & ~excl, req & ~excl} >> start);
    // rot bit 0 is the slot just after last_id; scanning downward lets the nearest one win
    always_comb begin
        found = 1'b0;
        off   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[IW'(k)]) begin
                found = 1'b1;
                off   = k;
            end
        end
        pos = int'(start) + off;
        idx = IW'(pos >= N_REQ ? pos - N_REQ : pos);
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the sync_fifo write port among producers
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = FIFO_DW,
    parameter int MAX_BURST = 4,
    localparam int IW = $clog2(N_REQ),
    localparam int BW = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ*DW-1:0] din,
    output logic [N_REQ-1:0]  ack,
    output logic              fifo_wr,
    output logic [DW-1:0]     fifo_datain,
    input  logic              fifo_full,
    output logic              grant_valid,
    output logic [IW-1:0]     grant_id
);
    arb_state_t       state;
    logic [IW-1:0]    last_id;
    logic [BW-1:0]    burst_cnt;
    logic             accept;
    logic             rel;
    logic             found;
    logic [IW-1:0]    pick_id;
    logic [IW-1:0]    pick_from;
    logic [N_REQ-1:0] pick_excl;

    assign grant_valid = state == GRANT;
    assign accept      = grant_valid & req[grant_id] & ~fifo_full;
    assign fifo_wr     = accept;
    assign ack         = N_REQ'(accept) << grant_id;
    assign fifo_datain = DW'(din >> (grant_id * DW));
    assign rel         = grant_valid & (~req[grant_id] | (accept & (burst_cnt == BW'(MAX_BURST - 1))));

    // idle searches past last_id; a releasing grant searches past itself and skips itself
    assign pick_from = grant_valid ? grant_id : last_id;
    assign pick_excl = grant_valid ? N_REQ'(1) << grant_id : '0;

    fifo_wr_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req     (req),
        .last_id (pick_from),
        .excl    (pick_excl),
        .found   (found),
        .idx     (pick_id)
    );

    // grant FSM: load winners, count accepted beats, hand over on drop or burst end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_id  <= '0;
            last_id   <= IW'(N_REQ - 1);
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                state     <= GRANT;
                grant_id  <= pick_id;
                burst_cnt <= '0;
            end
        end else if (rel) begin
            last_id   <= grant_id;
            burst_cnt <= '0;
            if (found)
                grant_id <= pick_id;
            else if (!req[grant_id])
                state <= IDLE;
        end else if (accept) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of the round-robin FIFO write arbiter
module tb_fifo_wr_arbiter;
    localparam int N = 4, DW = 8, MB = 4, DEPTH = 6;

    logic tb_sclk = 1'b0;
    logic rst_n   = 1'b0;
    logic [N-1:0] req, ack;
    logic [N*DW-1:0] din;
    logic fifo_wr, fifo_full, grant_valid;
    logic [DW-1:0] fifo_datain;
    logic [1:0] grant_id;

    int vectors = 0, miscompares = 0;
    logic [DW-1:0] pq[N][$];
    bit drop[N];
    int n_ack[N];
    logic [DW-1:0] fq[$], rb[$], exp_log[$];
    bit rd_en;
    bit m_valid;
    int m_id, m_last, m_beats;
    bit e_acc;
    logic [N-1:0] e_ack;
    logic [DW-1:0] e_data;

    fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(tb_sclk), .rst_n(rst_n), .req(req), .din(din), .ack(ack),
        .fifo_wr(fifo_wr), .fifo_datain(fifo_datain), .fifo_full(fifo_full),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 tb_sclk = ~tb_sclk;

    function automatic bit rq(int j);
        return bit'(req >> j);
    endfunction

    task automatic drive();
        logic [N-1:0] r = '0;
        logic [N*DW-1:0] d = '0;
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0 && !drop[i]) r |= N'(1) << i;
            d |= (N*DW)'(pq[i].size() > 0 ? pq[i][0] : DW'($urandom)) << (i * DW);
        end
        req = r;
        din = d;
        fifo_full = fq.size() >= DEPTH;
    endtask

    function automatic void predict();
        e_acc  = m_valid && rq(m_id) && !fifo_full;
        e_ack  = e_acc ? N'(1) << m_id : '0;
        e_data = e_acc ? pq[m_id][0] : '0;
    endfunction

    function automatic logic [N+DW+3:0] obs();
        return {ack, fifo_wr, grant_valid, grant_id, e_acc ? fifo_datain : DW'(0)};
    endfunction

    function automatic logic [N+DW+3:0] want();
        return {e_ack, e_acc, m_valid, 2'(m_id), e_data};
    endfunction

    task automatic advance();
        int nxt = -1;
        for (int i = 0; i < N; i++) n_ack[i] += int'((ack >> i) & N'(1));
        if (rd_en && fq.size() > 0) rb.push_back(fq.pop_front());
        if (fifo_wr) fq.push_back(fifo_datain);
        if (e_acc) exp_log.push_back(pq[m_id].pop_front());
        if (!m_valid) begin
            for (int k = N; k >= 1; k--) if (rq((m_last + k) % N)) nxt = (m_last + k) % N;
            if (nxt >= 0) begin m_valid = 1; m_id = nxt; m_beats = 0; end
        end else begin
            m_beats += int'(e_acc);
            if (!rq(m_id) || (e_acc && m_beats == MB)) begin
                for (int k = N - 1; k >= 1; k--) if (rq((m_id + k) % N)) nxt = (m_id + k) % N;
                m_last  = m_id;
                m_beats = 0;
                if (nxt >= 0) m_id = nxt;
                else if (!rq(m_id)) m_valid = 0;
            end
        end
        @(posedge tb_sclk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin pq[i].delete(); drop[i] = 0; n_ack[i] = 0; end
        fq.delete(); rb.delete(); exp_log.delete();
        rd_en = 1;
        m_valid = 0; m_id = 0; m_last = N - 1; m_beats = 0;
        drive();
        @(posedge tb_sclk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) pq[i].push_back(DW'(8'h50 + i));
        drive();
        repeat (3) begin
            @(negedge tb_sclk);
            vectors++;
            if ({ack, fifo_wr, grant_valid, grant_id} !== '0) begin
                miscompares++;
                $display("FAIL reset: ack=%b wr=%b gv=%b gid=%0d, all required 0", ack, fifo_wr, grant_valid, grant_id);
            end
        end
    endtask

    task automatic test_single_stream();
        do_reset();
        for (int w = 0; w < 10; w++) pq[0].push_back(DW'(w));
        drive();
        for (int c = 0; c < 16; c++) begin
            @(negedge tb_sclk); predict(); vectors++;
            if (obs() !== want()) begin miscompares++; $display("FAIL stream c=%0d observed %h expected %h", c, obs(), want()); end
            advance();
        end
        vectors++;
        if (rb.size() != 10) begin miscompares++; $display("FAIL stream_count got %0d required 10", rb.size()); end
        foreach (rb[i]) begin
            vectors++;
            if (rb[i] !== DW'(i)) begin miscompares++; $display("FAIL stream_data idx=%0d got %h required %h", i, rb[i], DW'(i)); end
        end
    endtask

    task automatic test_all_requesting();
        do_reset();
        for (int p = 0; p < N; p++) for (int w = 0; w < 8; w++) pq[p].push_back(DW'(8'hA0 + 16 * p + w));
        drive();
        for (int c = 0; c < 36; c++) begin
            @(negedge tb_sclk); predict(); vectors++;
            if (obs() !== want()) begin miscompares++; $display("FAIL all_req c=%0d observed %h expected %h", c, obs(), want()); end
            if (c >= 1 && c <= 32) begin
                vectors++;
                if (fifo_wr !== 1'b1 || grant_id !== 2'(((c - 1) / 4) % 4)) begin
                    miscompares++;
                    $display("FAIL rr_order c=%0d got wr=%b gid=%0d required wr=1 gid=%0d", c, fifo_wr, grant_id, ((c - 1) / 4) % 4);
                end
            end
            advance();
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        rd_en = 0;
        for (int w = 0; w < 8; w++) begin pq[0].push_back(DW'(8'h10 + w)); pq[1].push_back(DW'(8'h20 + w)); end
        drive();
        for (int c = 0; c < 46; c++) begin
            @(negedge tb_sclk); predict(); vectors++;
            if (obs() !== want()) begin miscompares++; $display("FAIL full_stall c=%0d observed %h expected %h", c, obs(), want()); end
            if (c == 13) begin
                vectors++;
                if (fq.size() != DEPTH) begin miscompares++; $display("FAIL stall_fill got %0d words required %0d", fq.size(), DEPTH); end
                rd_en = 1;
            end
            advance();
        end
        vectors++;
        if (rb.size() != 16) begin miscompares++; $display("FAIL stall_count got %0d required 16", rb.size()); end
        foreach (rb[i]) begin
            logic [DW-1:0] w = DW'(((i / 4) % 2 ? 8'h20 : 8'h10) + (i / 8) * 4 + i % 4);
            vectors++;
            if (rb[i] !== w) begin miscompares++; $display("FAIL stall_data idx=%0d got %h required %h", i, rb[i], w); end
        end
    endtask

    task automatic test_drop();
        int got2 = 0, last2 = -1, first3 = -1, bad = 0;
        do_reset();
        for (int w = 0; w < 4; w++) begin pq[2].push_back(DW'(8'h30 + w)); pq[3].push_back(DW'(8'h40 + w)); end
        drive();
        for (int c = 0; c < 14; c++) begin
            @(negedge tb_sclk); predict(); vectors++;
            if (obs() !== want()) begin miscompares++; $display("FAIL drop c=%0d observed %h expected %h", c, obs(), want()); end
            if (ack[2]) last2 = c;
            if (ack[3] && first3 < 0) first3 = c;
            if (e_acc && m_id == 2) got2++;
            if (got2 == 2) drop[2] = 1;
            advance();
        end
        foreach (rb[i]) if (rb[i] == 8'h32 || rb[i] == 8'h33) bad++;
        foreach (fq[i]) if (fq[i] == 8'h32 || fq[i] == 8'h33) bad++;
        vectors++;
        if (n_ack[2] != 2 || n_ack[3] != 4 || bad != 0) begin
            miscompares++;
            $display("FAIL drop_counts got ack2=%0d ack3=%0d stray=%0d required 2 4 0", n_ack[2], n_ack[3], bad);
        end
        vectors++;
        if (first3 != last2 + 2) begin miscompares++; $display("FAIL drop_handover first ack3 c=%0d required c=%0d", first3, last2 + 2); end
    endtask

    task automatic test_async_reset();
        int beats = 0;
        bit seen = 0;
        do_reset();
        for (int p = 0; p < N; p++) for (int w = 0; w < 8; w++) pq[p].push_back(DW'(8'hA0 + 16 * p + w));
        drive();
        for (int c = 0; c < 10 && beats < 2; c++) begin
            @(negedge tb_sclk); predict(); vectors++;
            if (obs() !== want()) begin miscompares++; $display("FAIL async_pre c=%0d observed %h expected %h", c, obs(), want()); end
            beats += int'(e_acc);
            advance();
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({ack, fifo_wr, grant_valid, grant_id} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: ack=%b wr=%b gv=%b gid=%0d, all required 0", ack, fifo_wr, grant_valid, grant_id);
        end
        m_valid = 0; m_id = 0; m_last = N - 1; m_beats = 0;
        @(posedge tb_sclk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge tb_sclk); predict(); vectors++;
            if (obs() !== want()) begin miscompares++; $display("FAIL async_post c=%0d observed %h expected %h", c, obs(), want()); end
            if (!seen && ack != '0) begin
                seen = 1;
                vectors++;
                if (ack !== 4'b0001 || fifo_datain !== 8'hA2) begin
                    miscompares++;
                    $display("FAIL async_first got ack=%b data=%h required ack=0001 data=a2", ack, fifo_datain);
                end
            end
            advance();
        end
        if (!seen) begin vectors++; miscompares++; $display("FAIL async_first no ack within 8 cycles after reset release"); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 460; c++) begin
            @(negedge tb_sclk); predict(); vectors++;
            if (obs() !== want()) begin miscompares++; $display("FAIL random c=%0d observed %h expected %h", c, obs(), want()); end
            if (c < 400) begin
                for (int i = 0; i < N; i++) begin
                    drop[i] = $urandom_range(0, 7) == 0;
                    if (pq[i].size() == 0 && $urandom_range(0, 3) == 0)
                        repeat ($urandom_range(1, 6)) pq[i].push_back(DW'($urandom));
                end
                rd_en = $urandom_range(0, 2) != 0;
            end else begin
                for (int i = 0; i < N; i++) drop[i] = 0;
                rd_en = 1;
            end
            advance();
        end
        vectors++;
        if (rb.size() != exp_log.size()) begin
            miscompares++;
            $display("FAIL random_count got %0d words required %0d", rb.size(), exp_log.size());
        end
        foreach (rb[i]) begin
            if (i < exp_log.size()) begin
                vectors++;
                if (rb[i] !== exp_log[i]) begin miscompares++; $display("FAIL random_data idx=%0d got %h required %h", i, rb[i], exp_log[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_all_requesting();
        test_full_stall();
        test_drop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
